// File: rtl/seg7_scan_display_pkg.sv
// Shared seven-segment definitions: the segment bit order and the active-low
// glyph patterns used by every display block in this slice.
package seg7_scan_display_pkg;

  // Segment bit positions within a pattern, packed as {g,f,e,d,c,b,a}.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-low glyphs: a 0 bit lights the segment.
  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;

  // All segments dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-nibble to active-low seven-segment decoder.
module seg7_hex_decode
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Full 0-F lookup; lower-case b and d keep them distinct from 8 and 0.
  always_comb begin
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed multi-digit seven-segment controller: digit scanning with an
// anti-ghosting gap, frame-synchronous double buffering, leading-zero
// blanking and per-digit blink. All display outputs are active-low.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 2,
  parameter int BLINK_FRAMES = 100
) (
  input  logic                  CLOCK_50,
  input  logic                  RST,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_blank,
  input  logic [DIGITS-1:0]     blink_en,
  output logic [6:0]            SEG,
  output logic                  DP,
  output logic [DIGITS-1:0]     DIG_SEL,
  output logic                  frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  logic [PW-1:0]         presc_p0;
  logic [IW-1:0]         idx_p0;
  logic                  tick;
  logic                  wrap;

  logic [4*DIGITS-1:0]   sh_val;
  logic [DIGITS-1:0]     sh_dp;
  logic                  sh_lz;
  logic                  pending;
  logic [4*DIGITS-1:0]   act_val;
  logic [DIGITS-1:0]     act_dp;
  logic                  act_lz;

  logic [BW-1:0]         blink_cnt;
  logic                  blink_hide;

  logic [DIGITS-1:0]     lz_mask;
  logic                  zero_run;
  logic [3:0]            cur_nib;
  logic [6:0]            dec_seg;

  logic [6:0]            seg_p1;
  logic                  dp_p1;
  logic [DIGITS-1:0]     sel_p1;

  // Slot terminal count and frame wrap (last slot of the last digit).
  always_comb begin
    tick = (presc_p0 == PW'(SCAN_DIV - 1));
    wrap = tick && (idx_p0 == IW'(DIGITS - 1));
  end

  assign frame_done = wrap;

  // Prescaler and digit index; the index steps once per slot.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      presc_p0 <= '0;
      idx_p0   <= '0;
    end else if (tick) begin
      presc_p0 <= '0;
      idx_p0   <= wrap ? '0 : idx_p0 + 1'b1;
    end else begin
      presc_p0 <= presc_p0 + 1'b1;
    end
  end

  // Shadow/active double buffer: active only changes on a frame wrap, so a
  // frame never shows a mix of old and new data. A load landing on the wrap
  // still hands over the previous shadow and keeps the new one pending.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      sh_val  <= '0;
      sh_dp   <= '0;
      sh_lz   <= 1'b0;
      pending <= 1'b0;
      act_val <= '0;
      act_dp  <= '0;
      act_lz  <= 1'b0;
    end else begin
      if (wrap && pending) begin
        act_val <= sh_val;
        act_dp  <= sh_dp;
        act_lz  <= sh_lz;
      end
      if (load) begin
        sh_val  <= value;
        sh_dp   <= dp_in;
        sh_lz   <= lz_blank;
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

  // Blink phase flips after every BLINK_FRAMES frame wraps.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      blink_cnt  <= '0;
      blink_hide <= 1'b0;
    end else if (wrap) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt  <= '0;
        blink_hide <= ~blink_hide;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Leading-zero mask: walk down from the top digit while nibbles stay zero;
  // digit 0 always stays visible so a zero value still shows "0".
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (act_val[4*i +: 4] == 4'h0);
      lz_mask[i] = act_lz & zero_run & (i != 0);
    end
  end

  // Nibble of the digit currently being scanned.
  always_comb begin
    cur_nib = act_val[{idx_p0, 2'b00} +: 4];
  end

  seg7_hex_decode u_dec (
    .nib (cur_nib),
    .seg (dec_seg)
  );

  // ---- p0 -> p1: registered pin drive for the current slot ----
  // Blank gap at slot start disables every digit; a leading-zero blanked
  // digit keeps its decimal point if that dp bit is set, while blink hides
  // both segments and point.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      seg_p1 <= SEG_OFF;
      dp_p1  <= 1'b1;
      sel_p1 <= '1;
    end else if (presc_p0 < PW'(BLANK_CYC)) begin
      seg_p1 <= SEG_OFF;
      dp_p1  <= 1'b1;
      sel_p1 <= '1;
    end else begin
      sel_p1 <= ~(DIGITS'(1) << idx_p0);
      if (blink_hide && blink_en[idx_p0]) begin
        seg_p1 <= SEG_OFF;
        dp_p1  <= 1'b1;
      end else begin
        seg_p1 <= lz_mask[idx_p0] ? SEG_OFF : dec_seg;
        dp_p1  <= ~act_dp[idx_p0];
      end
    end
  end

  assign SEG     = seg_p1;
  assign DP      = dp_p1;
  assign DIG_SEL = sel_p1;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: a table of load vectors with
// hand-computed per-digit patterns, plus sequences for buffering, blink and
// asynchronous reset.
module tb_seg7_scan_display;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYC    = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = DIGITS * SCAN_DIV;
  localparam int NVEC         = 23;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [3:0]  blink_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig_sel;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int fdcnt;
  int bnum;

  logic [6:0] cap_seg [FRAME];
  logic       cap_dp  [FRAME];
  logic [3:0] cap_sel [FRAME];

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dpv;
    logic        lz;
    logic [27:0] eseg;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t       vecs [NVEC];
  logic [6:0] hx   [16];

  seg7_scan_display #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYC    (BLANK_CYC),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .CLOCK_50   (clk),
    .RST        (rst),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .lz_blank   (lz_blank),
    .blink_en   (blink_en),
    .SEG        (seg),
    .DP         (dp),
    .DIG_SEL    (dig_sel),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent count of frame boundaries since reset, for the blink model.
  always @(posedge clk or posedge rst) begin
    if (rst) fdcnt <= 0;
    else if (frame_done) fdcnt <= fdcnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] d, input logic l);
    @(negedge clk);
    value    = v;
    dp_in    = d;
    lz_blank = l;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Wait for a frame_done cycle, then record outputs for the following frame.
  // cap index t = digit*SCAN_DIV + prescaler. Returns at the negedge of the
  // next frame_done cycle so frames can be captured back to back.
  task automatic capture_frame(input logic fd_load, input logic mid_load, input logic [15:0] lv);
    int k;
    k = 0;
    while (!frame_done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("frame_wait", {31'd0, frame_done}, 32'd1);
    if (fd_load) begin
      value = lv;
      load  = 1'b1;
    end
    @(posedge clk);
    #1 load = 1'b0;
    for (int t = 0; t < FRAME - 1; t++) begin
      @(posedge clk);
      @(negedge clk);
      cap_seg[t] = seg;
      cap_dp[t]  = dp;
      cap_sel[t] = dig_sel;
      if (t == 0) bnum = fdcnt;
      if (mid_load && t == 10) begin
        value = lv;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  task automatic check_frame(input logic [27:0] eseg, input logic [3:0] edp, input string tag);
    logic [3:0] es;
    for (int i = 0; i < DIGITS; i++) begin
      es    = 4'b1111;
      es[i] = 1'b0;
      chk($sformatf("%s_d%0d_seg", tag, i), cap_seg[i*SCAN_DIV + 4], eseg[i*7 +: 7]);
      chk($sformatf("%s_d%0d_dp", tag, i), cap_dp[i*SCAN_DIV + 4], edp[i]);
      chk($sformatf("%s_d%0d_sel", tag, i), cap_sel[i*SCAN_DIV + 4], es);
      chk($sformatf("%s_d%0d_gapsel", tag, i), cap_sel[i*SCAN_DIV], 4'hF);
      chk($sformatf("%s_d%0d_gapseg", tag, i), cap_seg[i*SCAN_DIV], 7'h7F);
    end
  endtask

  initial begin
    logic hidden;
    logic [6:0] d0;

    hx = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int n = 0; n < 16; n++)
      vecs[n] = '{16'(n), 4'h0, 1'b0, {7'h40, 7'h40, 7'h40, hx[n]}};
    vecs[16] = '{16'h0050, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}};
    vecs[17] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[18] = '{16'h0000, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[19] = '{16'h1234, 4'b0000, 1'b1, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[20] = '{16'h0000, 4'b0100, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[21] = '{16'hABCD, 4'b1001, 1'b0, {7'h08, 7'h03, 7'h46, 7'h21}};
    vecs[22] = '{16'h0F00, 4'b0000, 1'b1, {7'h7F, 7'h0E, 7'h40, 7'h40}};

    load = 1'b0; value = '0; dp_in = '0; lz_blank = 1'b0; blink_en = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_sel", dig_sel, 4'hF);
    chk("rst_fd", frame_done, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Basic scan of 1234.
    load_val(16'h1234, 4'h0, 1'b0);
    capture_frame(1'b0, 1'b0, 16'h0);
    check_frame({7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, "scan1234");

    // Decode sweep, blanking and decimal-point vectors.
    for (int v = 0; v < NVEC; v++) begin
      load_val(vecs[v].val, vecs[v].dpv, vecs[v].lz);
      capture_frame(1'b0, 1'b0, 16'h0);
      check_frame(vecs[v].eseg, ~vecs[v].dpv, $sformatf("vec%0d", v));
    end

    // Double buffering: mid-frame load waits for the boundary; a load on the
    // boundary cycle waits one more frame.
    load_val(16'h1234, 4'h0, 1'b0);
    capture_frame(1'b0, 1'b0, 16'h0);
    check_frame({7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, "buf_pre");
    capture_frame(1'b0, 1'b1, 16'hABCD);
    check_frame({7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, "buf_mid");
    capture_frame(1'b1, 1'b0, 16'h1111);
    check_frame({7'h08, 7'h03, 7'h46, 7'h21}, 4'hF, "buf_new");
    capture_frame(1'b0, 1'b0, 16'h0);
    check_frame({7'h79, 7'h79, 7'h79, 7'h79}, 4'hF, "buf_fd");

    // Blink on digit 0 only.
    blink_en = 4'b0001;
    load_val(16'h8888, 4'h0, 1'b0);
    for (int f = 0; f < 5; f++) begin
      capture_frame(1'b0, 1'b0, 16'h0);
      hidden = ((bnum / BLINK_FRAMES) % 2) == 1;
      d0 = hidden ? 7'h7F : 7'h00;
      check_frame({7'h00, 7'h00, 7'h00, d0}, 4'hF, $sformatf("blink%0d", f));
    end
    blink_en = 4'b0000;

    // Asynchronous reset during digit 2 with a load still pending.
    load_val(16'h5555, 4'h0, 1'b0);
    repeat (20) @(negedge clk);
    chk("pre_rst_sel", dig_sel, 4'b1011);
    #2 rst = 1'b1;
    #1;
    chk("arst_seg", seg, 7'h7F);
    chk("arst_dp", dp, 1'b1);
    chk("arst_sel", dig_sel, 4'hF);
    chk("arst_fd", frame_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("restart_gap_sel", dig_sel, 4'hF);
    @(posedge clk); @(negedge clk);
    chk("restart_d0_sel", dig_sel, 4'b1110);
    chk("restart_d0_seg", seg, 7'h40);
    capture_frame(1'b0, 1'b0, 16'h0);
    check_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, "post_rst0");
    capture_frame(1'b0, 1'b0, 16'h0);
    check_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, "post_rst1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
